// File: rtl/enet_boot_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : enet_boot_rom_arbiter
// Description : Two-master round-robin burst arbiter for the single-port
//               Ethernet boot ROM (384 x 32, registered address). Issues one
//               ROM address per clock, routes read data back to the burst
//               owner one cycle later and zeroes out-of-range beats.
// Revision    : 1.0 - initial release
// ============================================================================
module enet_boot_rom_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DEPTH     = 384,
    parameter int BURST_W   = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    // master 0: Nios instruction master
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic [BURST_W-1:0]  m0_burstcount,
    output logic                m0_waitrequest,
    output logic [31:0]         m0_readdata,
    output logic                m0_readdatavalid,
    // master 1: boot-loader copy DMA
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic [BURST_W-1:0]  m1_burstcount,
    output logic                m1_waitrequest,
    output logic [31:0]         m1_readdata,
    output logic                m1_readdatavalid,
    // ROM side
    output logic [ADDR_W-1:0]   rom_address,
    input  logic [31:0]         rom_readdata,
    // error reporting
    input  logic                err_clr,
    output logic                err_oor
);

    localparam logic [0:0]         S_IDLE      = 1'b0;
    localparam logic [0:0]         S_BURST     = 1'b1;
    localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [BURST_W-1:0] c_MAX_LEN   = BURST_W'(MAX_BURST);
    localparam logic [BURST_W-1:0] c_ONE       = BURST_W'(1);

    // Next word address; the populated region wraps back to word 0.
    function automatic logic [ADDR_W-1:0] f_inc(input logic [ADDR_W-1:0] a);
        return (a == c_LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    // Effective burst length: 0 means one beat, oversize clamps to the max.
    function automatic logic [BURST_W-1:0] f_len(input logic [BURST_W-1:0] b);
        if (b == '0)
            return c_ONE;
        else if (b > c_MAX_LEN)
            return c_MAX_LEN;
        else
            return b;
    endfunction

    logic [0:0]         state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [BURST_W-1:0] beats_left_q, beats_left_d;
    logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
    logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
    logic               issue_valid_q, issue_owner_q, issue_oor_q;
    logic [31:0]        rd0_q, rd0_d, rd1_q, rd1_d;
    logic               err_q, err_d;

    logic               w_grant0, w_grant1;
    logic               w_issue, w_issue_owner, w_issue_oor;
    logic [ADDR_W-1:0]  w_issue_addr;
    logic [BURST_W-1:0] w_grant_len;
    logic               w_ret0, w_ret1, w_oor_ret;
    logic [31:0]        w_ret_data;

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next state: a multi-beat grant enters BURST, the final beat leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if ((w_grant0 || w_grant1) && (w_grant_len > c_ONE)) state_d = S_BURST;
            S_BURST: if (beats_left_q == c_ONE) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: round-robin grant in IDLE, sequential beat issue in BURST.
    always_comb begin
        w_grant0      = 1'b0;
        w_grant1      = 1'b0;
        w_issue       = 1'b0;
        w_issue_owner = 1'b0;
        w_issue_addr  = next_addr_q;
        case (state_q)
            S_IDLE: begin
                // last_grant_q == 1 means master 1 went last, so master 0 wins a tie
                w_grant0      = m0_read & (~m1_read | last_grant_q);
                w_grant1      = m1_read & (~m0_read | ~last_grant_q);
                w_issue       = w_grant0 | w_grant1;
                w_issue_owner = w_grant1;
                w_issue_addr  = w_grant1 ? m1_address : m0_address;
            end
            S_BURST: begin
                w_issue       = 1'b1;
                w_issue_owner = owner_q;
                w_issue_addr  = next_addr_q;
            end
            default: ;
        endcase
    end

    assign w_grant_len    = f_len(w_grant1 ? m1_burstcount : m0_burstcount);
    assign w_issue_oor    = (32'(w_issue_addr) >= 32'(DEPTH));
    assign m0_waitrequest = ~w_grant0;
    assign m1_waitrequest = ~w_grant1;
    // ROM address holds its last value when nothing is issued
    assign rom_address    = w_issue ? w_issue_addr : rom_addr_q;

    // Return path: the beat issued last cycle is delivered to its owner now.
    assign w_ret0     = issue_valid_q & ~issue_owner_q;
    assign w_ret1     = issue_valid_q &  issue_owner_q;
    assign w_oor_ret  = issue_valid_q &  issue_oor_q;
    assign w_ret_data = issue_oor_q ? 32'd0 : rom_readdata;

    assign m0_readdatavalid = w_ret0;
    assign m1_readdatavalid = w_ret1;
    assign m0_readdata      = w_ret0 ? w_ret_data : rd0_q;
    assign m1_readdata      = w_ret1 ? w_ret_data : rd1_q;
    // Flag is visible in the return cycle itself; a set beats a same-cycle clear
    assign err_oor          = err_q | w_oor_ret;

    // Datapath next-state: burst bookkeeping, held read data and sticky error.
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        beats_left_d = beats_left_q;
        next_addr_d  = next_addr_q;
        if (state_q == S_IDLE) begin
            if (w_grant0 || w_grant1) begin
                last_grant_d = w_grant1;
                owner_d      = w_grant1;
                beats_left_d = w_grant_len - c_ONE;
                next_addr_d  = f_inc(w_issue_addr);
            end
        end else begin
            beats_left_d = beats_left_q - c_ONE;
            next_addr_d  = f_inc(next_addr_q);
        end
        rom_addr_d = w_issue ? w_issue_addr : rom_addr_q;
        rd0_d      = w_ret0 ? w_ret_data : rd0_q;
        rd1_d      = w_ret1 ? w_ret_data : rd1_q;
        err_d      = w_oor_ret | (err_q & ~err_clr);
    end

    // Datapath registers; reset drops a pending return beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q  <= 1'b1;
            owner_q       <= 1'b0;
            beats_left_q  <= '0;
            next_addr_q   <= '0;
            rom_addr_q    <= '0;
            issue_valid_q <= 1'b0;
            issue_owner_q <= 1'b0;
            issue_oor_q   <= 1'b0;
            rd0_q         <= '0;
            rd1_q         <= '0;
            err_q         <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            beats_left_q  <= beats_left_d;
            next_addr_q   <= next_addr_d;
            rom_addr_q    <= rom_addr_d;
            issue_valid_q <= w_issue;
            issue_owner_q <= w_issue_owner;
            issue_oor_q   <= w_issue_oor;
            rd0_q         <= rd0_d;
            rd1_q         <= rd1_d;
            err_q         <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enet_boot_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_enet_boot_rom_arbiter
// Description : Directed self-checking bench for enet_boot_rom_arbiter with a
//               behavioural ROM and an in-order return-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enet_boot_rom_arbiter;

    logic        clk;
    logic        reset_n;
    logic [8:0]  m0_address, m1_address;
    logic        m0_read, m1_read;
    logic [3:0]  m0_burstcount, m1_burstcount;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [8:0]  rom_address;
    logic [31:0] rom_readdata;
    logic        err_clr;
    logic        err_oor;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        m;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    enet_boot_rom_arbiter #(
        .ADDR_W(9), .DEPTH(384), .BURST_W(4), .MAX_BURST(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_read(m0_read), .m0_burstcount(m0_burstcount),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_burstcount(m1_burstcount),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .rom_address(rom_address), .rom_readdata(rom_readdata),
        .err_clr(err_clr), .err_oor(err_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM content pattern; also nonzero beyond DEPTH so aliasing would show
    function automatic logic [31:0] word(input logic [8:0] a);
        return 32'hA500_0000 | (32'(a) << 12) | 32'(a);
    endfunction

    // Behavioural ROM with registered address
    always @(posedge clk) rom_readdata <= word(rom_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic m, input logic [31:0] d);
        exp_t e;
        e.m = m;
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: every returned beat must match the oldest expected beat
    always @(negedge clk) begin
        if (m0_readdatavalid === 1'b1 || m1_readdatavalid === 1'b1) begin
            exp_t e;
            chk("rdv_exclusive", {31'b0, m0_readdatavalid & m1_readdatavalid}, 32'd0);
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL rdv_unexpected observed=m0:%0b/m1:%0b expected=no valid",
                       m0_readdatavalid, m1_readdatavalid);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rd_owner", {31'b0, m1_readdatavalid}, {31'b0, e.m});
                chk("rd_data", e.m ? m1_readdata : m0_readdata, e.d);
            end
        end
    end

    initial begin
        logic [8:0] wrap_seq [0:2];
        wrap_seq[0] = 9'd383;
        wrap_seq[1] = 9'd0;
        wrap_seq[2] = 9'd1;

        reset_n = 1'b0;
        m0_address = '0; m0_read = 1'b0; m0_burstcount = '0;
        m1_address = '0; m1_read = 1'b0; m1_burstcount = '0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // ---- reset state
        smp();
        chk("rst_m0_wait", {31'b0, m0_waitrequest}, 32'd1);
        chk("rst_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
        chk("rst_rom_addr", {23'b0, rom_address}, 32'd0);
        chk("rst_err", {31'b0, err_oor}, 32'd0);
        chk("rst_m0_rd", m0_readdata, 32'd0);
        chk("rst_m1_rd", m1_readdata, 32'd0);

        // ---- single beat from master 0
        cyc();
        m0_read = 1'b1; m0_address = 9'd5; m0_burstcount = 4'd1;
        push(1'b0, word(9'd5));
        smp();
        chk("t1_m0_wait", {31'b0, m0_waitrequest}, 32'd0);
        chk("t1_m1_wait", {31'b0, m1_waitrequest}, 32'd1);
        chk("t1_rom_addr", {23'b0, rom_address}, 32'd5);
        cyc();
        m0_read = 1'b0;
        smp();
        chk("t1_err", {31'b0, err_oor}, 32'd0);

        // ---- alternating single beats from reset
        cyc();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            m0_read = 1'b1; m0_address = 9'(10 + k); m0_burstcount = 4'd1;
            m1_read = 1'b1; m1_address = 9'(20 + k); m1_burstcount = 4'd1;
            push(k[0], k[0] ? word(9'(20 + k)) : word(9'(10 + k)));
            smp();
            chk("t2_m0_wait", {31'b0, m0_waitrequest}, {31'b0, k[0]});
            chk("t2_m1_wait", {31'b0, m1_waitrequest}, {31'b0, ~k[0]});
            chk("t2_rom_addr", {23'b0, rom_address}, k[0] ? 32'(20 + k) : 32'(10 + k));
        end
        cyc();
        m0_read = 1'b0; m1_read = 1'b0;
        smp();

        // ---- master 1 burst across the address wrap, master 0 held off
        cyc();
        m1_read = 1'b1; m1_address = 9'd382; m1_burstcount = 4'd4;
        push(1'b1, word(9'd382));
        smp();
        chk("t3_m1_wait", {31'b0, m1_waitrequest}, 32'd0);
        chk("t3_rom_addr0", {23'b0, rom_address}, 32'd382);
        for (int i = 0; i < 3; i++) begin
            cyc();
            m1_read = 1'b0;
            m0_read = 1'b1; m0_address = 9'd50; m0_burstcount = 4'd1;
            push(1'b1, word(wrap_seq[i]));
            smp();
            chk("t3_m0_held", {31'b0, m0_waitrequest}, 32'd1);
            chk("t3_rom_addr", {23'b0, rom_address}, {23'b0, wrap_seq[i]});
        end
        cyc();
        push(1'b0, word(9'd50));
        smp();
        chk("t3_m0_grant", {31'b0, m0_waitrequest}, 32'd0);
        chk("t3_rom_addr4", {23'b0, rom_address}, 32'd50);
        cyc();
        m0_read = 1'b0;
        smp();

        // ---- out-of-range reads and the sticky error flag
        cyc();
        m0_read = 1'b1; m0_address = 9'd400; m0_burstcount = 4'd1;
        push(1'b0, 32'd0);
        smp();
        chk("t4_err_pre", {31'b0, err_oor}, 32'd0);
        cyc();
        m0_read = 1'b0;
        smp();
        chk("t4_err_set", {31'b0, err_oor}, 32'd1);
        cyc();
        err_clr = 1'b1;
        smp();
        chk("t4_err_sticky", {31'b0, err_oor}, 32'd1);
        cyc();
        err_clr = 1'b0;
        smp();
        chk("t4_err_clr", {31'b0, err_oor}, 32'd0);
        cyc();
        m0_read = 1'b1; m0_address = 9'd450; m0_burstcount = 4'd1;
        push(1'b0, 32'd0);
        smp();
        cyc();
        m0_read = 1'b0; err_clr = 1'b1;
        smp();
        chk("t4_err_ret_clr", {31'b0, err_oor}, 32'd1);
        cyc();
        err_clr = 1'b0;
        smp();
        chk("t4_err_set_wins", {31'b0, err_oor}, 32'd1);
        cyc();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;

        // ---- burstcount 0 gives one beat, 15 is clamped to 8
        m0_read = 1'b1; m0_address = 9'd100; m0_burstcount = 4'd0;
        push(1'b0, word(9'd100));
        smp();
        chk("t5_b0_wait", {31'b0, m0_waitrequest}, 32'd0);
        chk("t5_b0_rom", {23'b0, rom_address}, 32'd100);
        cyc();
        m0_address = 9'd200; m0_burstcount = 4'd15;
        push(1'b0, word(9'd200));
        smp();
        chk("t5_b0_single", {31'b0, m0_waitrequest}, 32'd0);
        chk("t5_b15_rom0", {23'b0, rom_address}, 32'd200);
        for (int i = 1; i < 8; i++) begin
            cyc();
            m0_read = 1'b0;
            m1_read = 1'b1; m1_address = 9'd300; m1_burstcount = 4'd1;
            push(1'b0, word(9'(200 + i)));
            smp();
            chk("t5_m1_held", {31'b0, m1_waitrequest}, 32'd1);
            chk("t5_b15_rom", {23'b0, rom_address}, 32'(200 + i));
        end
        cyc();
        push(1'b1, word(9'd300));
        smp();
        chk("t5_clamp8_m1_grant", {31'b0, m1_waitrequest}, 32'd0);
        chk("t5_m1_rom", {23'b0, rom_address}, 32'd300);
        cyc();
        m1_read = 1'b0;
        smp();

        // ---- asynchronous reset in beat 3 of an 8-beat burst
        cyc();
        m0_read = 1'b1; m0_address = 9'd10; m0_burstcount = 4'd8;
        push(1'b0, word(9'd10));
        smp();
        chk("t6_m0_wait", {31'b0, m0_waitrequest}, 32'd0);
        cyc();
        m0_read = 1'b0;
        push(1'b0, word(9'd11));
        smp();
        cyc();
        push(1'b0, word(9'd12));
        smp();
        cyc();
        smp();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_rom_addr", {23'b0, rom_address}, 32'd0);
        chk("t6_rst_m0_wait", {31'b0, m0_waitrequest}, 32'd1);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        smp();
        chk("t6_no_rdv", {31'b0, m0_readdatavalid | m1_readdatavalid}, 32'd0);
        cyc();
        m1_read = 1'b1; m1_address = 9'd30; m1_burstcount = 4'd1;
        push(1'b1, word(9'd30));
        smp();
        chk("t6_m1_grant", {31'b0, m1_waitrequest}, 32'd0);
        chk("t6_m1_rom", {23'b0, rom_address}, 32'd30);
        cyc();
        m1_read = 1'b0;
        smp();
        cyc();
        smp();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
